periph_uart_tx: RTL

//  Downstream consumer of the CPU's 16-bit peripheral output register.
//  - Captures each word the core writes to PeripheralBuffer (qualified by a write strobe) into a FIFO.
//  - Serialises each word as two 8N1 UART bytes: high byte first, LSB first within each byte.
//  - Decouples the pipeline from the slow serial line. No back-pressure into the core: a full FIFO drops the write.

---
 rtl/periph_uart_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/periph_uart_tx.sv
// periph_uart_tx: buffers 16-bit peripheral writes in a FIFO and sends each word as two UART bytes, high byte first.
// Build option PERIPH_TX_PARITY_EN: adds an even-parity bit to every byte (8E1 instead of 8N1).
module periph_uart_tx #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   periph_we,
  input  logic [15:0]            periph_data,
  input  logic                   ovf_clr,
  output logic                   tx,
  output logic                   busy,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef PERIPH_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [15:0]      shreg_q, shreg_d;
  logic             hi_sel_q, hi_sel_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             fifo_full_q, fifo_full_d;
  logic             overflow_q, overflow_d;

  logic             full, push, pop, drop, baud_done;
  logic [15:0]      rd_data;
  logic [7:0]       cur_byte;

  assign rd_data   = mem_q[rd_ptr_q];
  assign cur_byte  = hi_sel_q ? shreg_q[15:8] : shreg_q[7:0];
  assign baud_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Frame sequencer: pops a word, then START/DATA/(PARITY)/STOP for the high and low byte.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    hi_sel_d = hi_sel_q;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (level_q != '0) begin
          pop      = 1'b1;
          shreg_d  = rd_data;
          hi_sel_d = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef PERIPH_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef PERIPH_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          cnt_d = '0;
          if (hi_sel_q) begin
            hi_sel_d = 1'b0;
            state_d  = S_START;
          end else if (level_q != '0) begin
            // Back-to-back words: chain straight into the next start bit.
            pop      = 1'b1;
            shreg_d  = rd_data;
            hi_sel_d = 1'b1;
            state_d  = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a write into a full FIFO.
  always_comb begin
    full     = (level_q == LVL_W'(DEPTH));
    push     = periph_we && (!full || pop);
    drop     = periph_we && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    fifo_full_d = (level_d == LVL_W'(DEPTH));
    overflow_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);
  end

  // Line and busy are a registered view of the current state, so both lag it by one cycle.
  always_comb begin
    busy_d = (level_q != '0) || (state_q != S_IDLE);
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte[bit_q];
`ifdef PERIPH_TX_PARITY_EN
      S_PARITY: tx_d = ^cur_byte;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      hi_sel_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      hi_sel_q    <= hi_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      fifo_full_q <= fifo_full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= periph_data;
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign fifo_full = fifo_full_q;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule
